// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and funct3 encodings for the MEM-stage load/store unit.
// Branch encodings sit beside the memory ones so the decoder and LSU share one table.
package mem_stage_lsu_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } lsu_state_t;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;

    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and the
// alignment/legality decode of a memory op. Purely combinational.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (is_load && is_store) begin
            illegal = 1'b1;
        end else if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    wstrb      = 4'b0011 << addr_lo;
                    wdata      = {2{store_data[15:0]}};
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    wstrb      = 4'b1111;
                    misaligned = (addr_lo != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3)
                F3_LB:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                F3_LBU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
                F3_LH: begin
                    load_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
                    misaligned = addr_lo[0];
                end
                F3_LHU: begin
                    load_data  = {{(XLEN-16){1'b0}}, half_sel};
                    misaligned = addr_lo[0];
                end
                F3_LW: misaligned = (addr_lo != 2'b00);
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: registers ALU results through to writeback and runs the data-memory
// req/ack handshake for loads and stores, stalling EX while an access is outstanding.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            flush,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic            dmem_err,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned,
    output logic            access_fault,
    output logic [XLEN-1:0] fault_addr
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t      state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic            op_load_reg, op_we_reg, op_rw_reg, kill_reg;
    logic [2:0]      op_f3_reg;
    logic [XLEN-1:0] op_addr_reg, op_wdata_reg;
    logic [4:0]      op_rd_reg;
    logic [3:0]      op_wstrb_reg;

    logic            in_wait, accept, is_mem, go_wait, done_ok, done_err, timeout;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_load_data;
    logic            al_misaligned, al_illegal;

    assign in_wait  = (state_reg == S_WAIT);
    assign accept   = (state_reg == S_IDLE) && ex_valid && !flush;
    assign is_mem   = mem_read || mem_write;
    assign go_wait  = accept && is_mem && !al_illegal && !al_misaligned;
    assign done_err = in_wait && dmem_err;
    assign done_ok  = in_wait && dmem_ack && !dmem_err;
    assign timeout  = in_wait && !dmem_ack && !dmem_err && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // One aligner serves both phases: live EX op in IDLE, latched op in WAIT.
    mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (in_wait ? op_addr_reg[1:0] : alu_result[1:0]),
        .funct3     (in_wait ? op_f3_reg : funct3),
        .is_load    (in_wait ? op_load_reg : mem_read),
        .is_store   (in_wait ? op_we_reg : mem_write),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load_data),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go_wait) state_next = S_WAIT;
            S_WAIT:  if (done_ok || done_err || timeout) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ex_ready   = (state_reg == S_IDLE) && !reset;
        dmem_req   = in_wait;
        dmem_we    = in_wait && op_we_reg;
        dmem_addr  = in_wait ? {op_addr_reg[XLEN-1:2], 2'b00} : '0;
        dmem_wdata = in_wait ? op_wdata_reg : '0;
        dmem_wstrb = in_wait ? op_wstrb_reg : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            op_load_reg  <= 1'b0;
            op_we_reg    <= 1'b0;
            op_rw_reg    <= 1'b0;
            kill_reg     <= 1'b0;
            op_f3_reg    <= 3'b000;
            op_addr_reg  <= '0;
            op_wdata_reg <= '0;
            op_rd_reg    <= 5'd0;
            op_wstrb_reg <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            fault_addr   <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            if (accept && !is_mem) begin
                wb_valid     <= 1'b1;
                wb_data      <= alu_result;
                wb_rd        <= rd;
                wb_reg_write <= reg_write;
            end
            if (accept && is_mem) begin
                if (al_illegal) begin
                    access_fault <= 1'b1;
                    fault_addr   <= alu_result;
                end else if (al_misaligned) begin
                    misaligned <= 1'b1;
                    fault_addr <= alu_result;
                end else begin
                    op_load_reg  <= mem_read;
                    op_we_reg    <= mem_write;
                    op_f3_reg    <= funct3;
                    op_addr_reg  <= alu_result;
                    op_rd_reg    <= rd;
                    op_rw_reg    <= reg_write;
                    op_wstrb_reg <= al_wstrb;
                    op_wdata_reg <= al_wdata;
                    kill_reg     <= 1'b0;
                    cnt_reg      <= '0;
                end
            end
            if (in_wait) begin
                cnt_reg <= cnt_reg + CW'(1);
                // A store is already committed on the bus; only loads can be killed.
                if (flush && op_load_reg) kill_reg <= 1'b1;
                if (done_err || timeout) begin
                    access_fault <= 1'b1;
                    fault_addr   <= op_addr_reg;
                    cnt_reg      <= '0;
                end else if (done_ok) begin
                    wb_valid     <= !(kill_reg || (flush && op_load_reg));
                    wb_reg_write <= op_load_reg && op_rw_reg;
                    wb_rd        <= op_rd_reg;
                    wb_data      <= op_load_reg ? al_load_data : '0;
                    cnt_reg      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, randomized ops against a
// behavioural model, and hand-written flush/reset sequences.
module tb_mem_stage_lsu;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_ready, flush, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack, dmem_err;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned, access_fault;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .rd(rd), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .access_fault(access_fault), .fault_addr(fault_addr)
    );

    typedef struct {
        logic        r, w;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rdn;
        logic        rw;
        int          ack_after;   // req-cycle index of the response, -1 = never
        logic        err;
        logic [31:0] rdata;
        int          flush_at;    // req-cycle index where flush pulses, -1 = none
    } op_t;

    typedef struct {
        logic        wbv;
        logic [31:0] data;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic        mis, fault;
        logic [31:0] fa;
        int          req;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        wbv;
        logic [31:0] data;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic        mis, fault;
        logic [31:0] fa;
        int          req;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        ready_at_issue, ready_after, ready_bad, unstable, spurious, timed_out;
    } obs_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(logic r, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                                  logic [4:0] rdn, logic rw, int ack, logic err, logic [31:0] rdata, int fl);
        op_t o;
        o.r = r; o.w = w; o.f3 = f3; o.addr = a; o.sdata = d; o.rdn = rdn; o.rw = rw;
        o.ack_after = ack; o.err = err; o.rdata = rdata; o.flush_at = fl;
        return o;
    endfunction

    function automatic exp_t mk_exp(logic wbv, logic [31:0] data, logic wb_rw, logic [4:0] wb_rd,
                                    logic mis, logic fault, logic [31:0] fa, int req, logic we,
                                    logic [31:0] baddr, logic [3:0] wstrb, logic [31:0] wdata);
        exp_t e;
        e.wbv = wbv; e.data = data; e.wb_rw = wb_rw; e.wb_rd = wb_rd; e.mis = mis; e.fault = fault;
        e.fa = fa; e.req = req; e.we = we; e.baddr = baddr; e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    // Reference behaviour derived from the op's architectural meaning.
    function automatic exp_t model(op_t op);
        exp_t e;
        int size, off;
        logic [31:0] v;
        e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (!op.r && !op.w) begin
            e.wbv = 1; e.data = op.addr; e.wb_rw = op.rw; e.wb_rd = op.rdn;
            return e;
        end
        if ((op.r && op.w) || (op.r && (op.f3 == 3 || op.f3 == 6 || op.f3 == 7)) || (op.w && op.f3 > 2)) begin
            e.fault = 1; e.fa = op.addr;
            return e;
        end
        size = 1 << (op.f3 % 4);
        off  = int'(op.addr % 4);
        if (op.addr % size != 0) begin
            e.mis = 1; e.fa = op.addr;
            return e;
        end
        e.baddr = op.addr - off;
        e.we    = op.w;
        if (op.w) begin
            e.wstrb = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.wdata = (op.sdata % 256) * 32'h01010101;
            else if (size == 2) e.wdata = (op.sdata % 65536) * 32'h00010001;
            else                e.wdata = op.sdata;
        end
        if (op.ack_after < 0) begin
            e.req = TIMEOUT; e.fault = 1; e.fa = op.addr;
            return e;
        end
        e.req = op.ack_after + 1;
        if (op.err) begin
            e.fault = 1; e.fa = op.addr;
            return e;
        end
        e.wbv   = !(op.r && op.flush_at >= 0 && op.flush_at <= op.ack_after);
        e.wb_rw = op.r ? op.rw : 1'b0;
        e.wb_rd = op.rdn;
        if (op.r) begin
            v = op.rdata >> (8 * off);
            if (size == 1) begin
                v = v % 256;
                if (op.f3 < 4 && v >= 128) v = v + 32'hFFFFFF00;
            end else if (size == 2) begin
                v = v % 65536;
                if (op.f3 < 4 && v >= 32768) v = v + 32'hFFFF0000;
            end
            e.data = v;
        end
        return e;
    endfunction

    // Issues op at the current falling edge, plays the memory, returns at the
    // falling edge where the result pulses (EX may issue again right there).
    task automatic run_op(input op_t op, output obs_t o);
        int idx;
        bit done;
        o = '{default: '0};
        o.ready_at_issue = ex_ready;
        dmem_ack = 0; dmem_err = 0; flush = 0;
        ex_valid = 1; mem_read = op.r; mem_write = op.w; funct3 = op.f3;
        alu_result = op.addr; store_data = op.sdata; rd = op.rdn; reg_write = op.rw;
        @(negedge clk);
        ex_valid = 0; mem_read = 0; mem_write = 0;
        alu_result = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        idx = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            dmem_ack = 0; dmem_err = 0; flush = 0; dmem_rdata = $urandom;
            if (dmem_req) begin
                if (idx == 0) begin
                    o.we = dmem_we; o.baddr = dmem_addr; o.wstrb = dmem_wstrb; o.wdata = dmem_wdata;
                end else if (o.we !== dmem_we || o.baddr !== dmem_addr ||
                             o.wstrb !== dmem_wstrb || o.wdata !== dmem_wdata) begin
                    o.unstable = 1;
                end
                if (ex_ready) o.ready_bad = 1;
                if (wb_valid || misaligned || access_fault) o.spurious = 1;
                if (idx == op.ack_after) begin
                    dmem_ack = !op.err; dmem_err = op.err; dmem_rdata = op.rdata;
                end
                if (idx == op.flush_at) flush = 1;
                idx++;
                @(negedge clk);
            end else begin
                o.wbv = wb_valid; o.data = wb_data; o.wb_rw = wb_reg_write; o.wb_rd = wb_rd;
                o.mis = misaligned; o.fault = access_fault; o.fa = fault_addr;
                o.ready_after = ex_ready;
                done = 1;
            end
        end
        o.req = idx;
        o.timed_out = !done;
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        chk({tag, " ready_at_issue"}, 32'(o.ready_at_issue), 32'd1);
        chk({tag, " timed_out"}, 32'(o.timed_out), 32'd0);
        chk({tag, " ex_ready_during_req"}, 32'(o.ready_bad), 32'd0);
        chk({tag, " bus_unstable"}, 32'(o.unstable), 32'd0);
        chk({tag, " pulse_during_req"}, 32'(o.spurious), 32'd0);
        chk({tag, " req_cycles"}, 32'(o.req), 32'(e.req));
        chk({tag, " wb_valid"}, 32'(o.wbv), 32'(e.wbv));
        chk({tag, " misaligned"}, 32'(o.mis), 32'(e.mis));
        chk({tag, " access_fault"}, 32'(o.fault), 32'(e.fault));
        chk({tag, " ex_ready_after"}, 32'(o.ready_after), 32'd1);
        if (e.wbv) begin
            chk({tag, " wb_reg_write"}, 32'(o.wb_rw), 32'(e.wb_rw));
            chk({tag, " wb_rd"}, 32'(o.wb_rd), 32'(e.wb_rd));
            if (!e.we) chk({tag, " wb_data"}, o.data, e.data);
        end
        if (e.mis || e.fault) chk({tag, " fault_addr"}, o.fa, e.fa);
        if (e.req > 0) begin
            chk({tag, " dmem_addr"}, o.baddr, e.baddr);
            chk({tag, " dmem_we"}, 32'(o.we), 32'(e.we));
            if (e.we) begin
                chk({tag, " dmem_wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
                chk({tag, " dmem_wdata"}, o.wdata, e.wdata);
            end
        end
    endtask

    vec_t vecs[15];
    obs_t ob;
    op_t  rop;

    initial begin
        vecs[0]  = '{mk_op(1,0,3'd2,32'h100,0,5'd1,1,2,0,32'hDEADBEEF,-1), mk_exp(1,32'hDEADBEEF,1,5'd1,0,0,0,3,0,32'h100,0,0)};
        vecs[1]  = '{mk_op(1,0,3'd0,32'h103,0,5'd2,1,0,0,32'h80000000,-1), mk_exp(1,32'hFFFFFF80,1,5'd2,0,0,0,1,0,32'h100,0,0)};
        vecs[2]  = '{mk_op(1,0,3'd4,32'h103,0,5'd3,1,0,0,32'h80000000,-1), mk_exp(1,32'h00000080,1,5'd3,0,0,0,1,0,32'h100,0,0)};
        vecs[3]  = '{mk_op(1,0,3'd5,32'h102,0,5'd4,1,1,0,32'h80000000,-1), mk_exp(1,32'h00008000,1,5'd4,0,0,0,2,0,32'h100,0,0)};
        vecs[4]  = '{mk_op(1,0,3'd1,32'h102,0,5'd5,0,0,0,32'h80000000,-1), mk_exp(1,32'hFFFF8000,0,5'd5,0,0,0,1,0,32'h100,0,0)};
        vecs[5]  = '{mk_op(0,1,3'd1,32'h202,32'h1234ABCD,5'd6,1,0,0,0,-1), mk_exp(1,0,0,5'd6,0,0,0,1,1,32'h200,4'b1100,32'hABCDABCD)};
        vecs[6]  = '{mk_op(1,0,3'd2,32'h101,0,5'd7,1,0,0,0,-1),            mk_exp(0,0,0,0,1,0,32'h101,0,0,0,0,0)};
        vecs[7]  = '{mk_op(0,0,3'd0,32'd5,0,5'd8,1,0,0,0,-1),              mk_exp(1,32'd5,1,5'd8,0,0,0,0,0,0,0,0)};
        vecs[8]  = '{mk_op(0,1,3'd2,32'h300,32'h11,5'd9,0,1,1,0,-1),       mk_exp(0,0,0,0,0,1,32'h300,2,1,32'h300,4'hF,32'h11)};
        vecs[9]  = '{mk_op(1,0,3'd3,32'h304,0,5'd10,1,0,0,0,-1),           mk_exp(0,0,0,0,0,1,32'h304,0,0,0,0,0)};
        vecs[10] = '{mk_op(1,1,3'd2,32'h308,0,5'd11,1,0,0,0,-1),           mk_exp(0,0,0,0,0,1,32'h308,0,0,0,0,0)};
        vecs[11] = '{mk_op(1,0,3'd2,32'h400,0,5'd12,1,1,0,32'h55,0),       mk_exp(0,0,0,0,0,0,0,2,0,32'h400,0,0)};
        vecs[12] = '{mk_op(0,1,3'd0,32'h201,32'h55,5'd13,1,0,0,0,0),       mk_exp(1,0,0,5'd13,0,0,0,1,1,32'h200,4'b0010,32'h55555555)};
        vecs[13] = '{mk_op(1,0,3'd1,32'h203,0,5'd14,1,0,0,0,-1),           mk_exp(0,0,0,0,1,0,32'h203,0,0,0,0,0)};
        vecs[14] = '{mk_op(1,0,3'd2,32'h500,0,5'd15,1,-1,0,0,-1),          mk_exp(0,0,0,0,0,1,32'h500,TIMEOUT,0,32'h500,0,0)};

        reset = 1; ex_valid = 0; flush = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        alu_result = 0; store_data = 0; rd = 0; reg_write = 0;
        dmem_ack = 0; dmem_err = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("reset ex_ready", 32'(ex_ready), 0);
        chk("reset dmem_req", 32'(dmem_req), 0);
        chk("reset wb_valid", 32'(wb_valid), 0);
        chk("reset fault_addr", fault_addr, 0);
        reset = 0;
        @(negedge clk);
        chk("post-reset ex_ready", 32'(ex_ready), 1);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, ob);
            $display("vec %0d: op r=%0b w=%0b f3=%0d addr=%h -> wbv=%0b data=%h mis=%0b fault=%0b req=%0d",
                     i, vecs[i].op.r, vecs[i].op.w, vecs[i].op.f3, vecs[i].op.addr,
                     ob.wbv, ob.data, ob.mis, ob.fault, ob.req);
            compare($sformatf("vec%0d", i), ob, vecs[i].e);
        end

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 7);
            rop = mk_op(0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                        1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, -1);
            if (kind >= 1 && kind <= 3) rop.r = 1;
            if (kind >= 4 && kind <= 6) begin rop.w = 1; rop.f3 = 3'($urandom_range(0, 3)); end
            if (kind == 7) begin rop.r = 1; rop.w = 1; end
            if ($urandom_range(0, 3) == 0) rop.flush_at = $urandom_range(0, rop.ack_after);
            run_op(rop, ob);
            $display("rnd %0d: op r=%0b w=%0b f3=%0d addr=%h -> wbv=%0b data=%h mis=%0b fault=%0b req=%0d",
                     i, rop.r, rop.w, rop.f3, rop.addr, ob.wbv, ob.data, ob.mis, ob.fault, ob.req);
            compare($sformatf("rnd%0d", i), ob, model(rop));
        end

        // Flush in IDLE blocks acceptance of both mem and non-mem ops.
        ex_valid = 1; flush = 1; mem_read = 1; funct3 = 3'd2; alu_result = 32'h600;
        @(negedge clk);
        ex_valid = 0; flush = 0; mem_read = 0;
        chk("flush-accept load dmem_req", 32'(dmem_req), 0);
        chk("flush-accept load wb_valid", 32'(wb_valid), 0);
        ex_valid = 1; flush = 1; alu_result = 32'h7;
        @(negedge clk);
        ex_valid = 0; flush = 0;
        chk("flush-accept alu wb_valid", 32'(wb_valid), 0);
        chk("flush-accept ex_ready", 32'(ex_ready), 1);
        $display("seq flush-at-accept: req=%0b wb_valid=%0b", dmem_req, wb_valid);

        // Reset mid-WAIT abandons the transaction.
        ex_valid = 1; mem_read = 1; funct3 = 3'd2; alu_result = 32'h700;
        @(negedge clk);
        ex_valid = 0; mem_read = 0;
        chk("rst-wait dmem_req before", 32'(dmem_req), 1);
        reset = 1;
        @(negedge clk);
        chk("rst-wait dmem_req", 32'(dmem_req), 0);
        chk("rst-wait ex_ready", 32'(ex_ready), 0);
        chk("rst-wait wb_valid", 32'(wb_valid), 0);
        chk("rst-wait access_fault", 32'(access_fault), 0);
        chk("rst-wait fault_addr", fault_addr, 0);
        reset = 0;
        @(negedge clk);
        chk("rst-wait ex_ready after", 32'(ex_ready), 1);
        chk("rst-wait dmem_req after", 32'(dmem_req), 0);
        $display("seq reset-in-wait: req=%0b ex_ready=%0b", dmem_req, ex_ready);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
